// File: rtl/int_to_fp_sched.sv
// Shared signed-integer to floating-point converter.
// A round-robin arbiter accepts one 8-bit sign-magnitude request at a time.
// The magnitude is normalised one bit per clock into a 1-bit sign, a 4-bit
// exponent and an 8-bit fraction, and the result is held until downstream accepts it.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request; the grant is offered on req_ready
// NORM  | shifting the magnitude left until its leading one reaches bit 7
// DONE  | result presented on out_*; waiting for out_ready
module int_to_fp_sched #(
    parameter int ID_W = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [(2**ID_W)-1:0]       req_valid,
    input  logic [(8*(2**ID_W))-1:0]   req_data,
    output logic [(2**ID_W)-1:0]       req_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ID_W-1:0]            out_id,
    output logic                       out_sign,
    output logic [3:0]                 out_exp,
    output logic [7:0]                 out_frac,
    output logic                       busy
);
    localparam int N = 2**ID_W;

    typedef enum logic [1:0] {S_IDLE, S_NORM, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [7:0]      sreg_q, sreg_d;
    logic [3:0]      ecnt_q, ecnt_d;
    logic            sign_q, sign_d;
    logic [ID_W-1:0] id_q, id_d;
    logic            out_valid_q, out_valid_d;
    logic [ID_W-1:0] out_id_q, out_id_d;
    logic            out_sign_q, out_sign_d;
    logic [3:0]      out_exp_q, out_exp_d;
    logic [7:0]      out_frac_q, out_frac_d;

    logic            found;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] idx;
    logic [7:0]      win_data;
    logic [N-1:0]    grant;

    // Round-robin search starting at the pointer; N is a power of two so the
    // ID_W-bit sum wraps modulo N on its own.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        idx      = '0;
        win_data = '0;
        for (int k = 0; k < N; k++) begin
            idx = ptr_q + ID_W'(k);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (win == ID_W'(k)) win_data = req_data[8*k +: 8];
        end
        grant = found ? (N'(1) << win) : '0;
    end

    // Next-state and datapath updates for the IDLE/NORM/DONE sequence.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sreg_d      = sreg_q;
        ecnt_d      = ecnt_q;
        sign_d      = sign_q;
        id_d        = id_q;
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        out_sign_d  = out_sign_q;
        out_exp_d   = out_exp_q;
        out_frac_d  = out_frac_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    sign_d  = win_data[7];
                    sreg_d  = {win_data[6:0], 1'b0};
                    ecnt_d  = 4'd7;
                    id_d    = win;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (sreg_q == 8'd0 || sreg_q[7]) begin
                    out_exp_d   = (sreg_q == 8'd0) ? 4'd0 : ecnt_q;
                    out_frac_d  = sreg_q;
                    out_sign_d  = sign_q;
                    out_id_d    = id_q;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    sreg_d = sreg_q << 1;
                    ecnt_d = ecnt_q - 4'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    ptr_d       = id_q + ID_W'(1);
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset; an in-flight job is simply dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            sreg_q      <= '0;
            ecnt_q      <= '0;
            sign_q      <= 1'b0;
            id_q        <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_sign_q  <= 1'b0;
            out_exp_q   <= '0;
            out_frac_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sreg_q      <= sreg_d;
            ecnt_q      <= ecnt_d;
            sign_q      <= sign_d;
            id_q        <= id_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_sign_q  <= out_sign_d;
            out_exp_q   <= out_exp_d;
            out_frac_q  <= out_frac_d;
        end
    end

    assign req_ready = (state_q == S_IDLE && !reset) ? grant : '0;
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out_sign  = out_sign_q;
    assign out_exp   = out_exp_q;
    assign out_frac  = out_frac_q;
endmodule

// File: tb/tb_int_to_fp_sched.sv
// Bench for int_to_fp_sched: directed scenarios followed by random traffic,
// checked cycle by cycle against a job-level reference model.
module tb_int_to_fp_sched;
    localparam int ID_W = 2;
    localparam int N    = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic           out_ready;
    logic [ID_W-1:0] out_id;
    logic           out_sign;
    logic [3:0]     out_exp;
    logic [7:0]     out_frac;
    logic           busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: one job in flight, counted down in clock edges.
    int  m_busy  = 0;
    int  m_valid = 0;
    int  m_ptr   = 0;
    int  m_cnt   = 0;
    int  j_id, j_sign, j_exp, j_frac;
    int  obs_ids[$];

    int_to_fp_sched #(.ID_W(ID_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_frac  (out_frac),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
        end
    endtask

    function automatic int msb_pos(input int mag);
        int p = -1;
        for (int b = 0; b < 7; b++) if ((mag >> b) & 1) p = b;
        return p;
    endfunction

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic tick();
        int w;
        int idx;
        int d;
        int p;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        w = -1;
        if (!m_busy && !reset) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (w < 0 && req_valid[idx]) w = idx;
            end
        end
        exp_rdy = '0;
        if (w >= 0) exp_rdy[w] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("busy", 32'(busy), 32'(m_busy));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            check("out_id", 32'(out_id), 32'(j_id));
            check("out_sign", 32'(out_sign), 32'(j_sign));
            check("out_exp", 32'(out_exp), 32'(j_exp));
            check("out_frac", 32'(out_frac), 32'(j_frac));
            if (out_ready) obs_ids.push_back(int'(out_id));
        end
        @(posedge clk);
        if (reset) begin
            m_busy = 0; m_valid = 0; m_ptr = 0;
        end else if (!m_busy) begin
            if (w >= 0) begin
                d      = int'(req_data[8*w +: 8]);
                p      = msb_pos(d & 127);
                j_id   = w;
                j_sign = (d >> 7) & 1;
                j_exp  = (p < 0) ? 0 : p + 1;
                j_frac = (p < 0) ? 0 : (((d & 127) << (7 - p)) & 255);
                m_cnt  = (p < 0) ? 1 : 7 - p;
                m_busy = 1;
            end
        end else if (!m_valid) begin
            m_cnt--;
            if (m_cnt == 0) m_valid = 1;
        end else if (out_ready) begin
            m_valid = 0;
            m_busy  = 0;
            m_ptr   = (j_id + 1) % N;
        end
        #1;
    endtask

    task automatic run_until_idle(input int max_cycles);
        int n = 0;
        while (m_busy && n < max_cycles) begin
            tick();
            n++;
        end
        if (m_busy) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic single(input int id, input logic [7:0] d);
        req_valid     = '0;
        req_valid[id] = 1'b1;
        req_data[8*id +: 8] = d;
        tick();
        req_valid = '0;
        req_data  = '1;
        run_until_idle(20);
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_id", 32'(out_id), 32'd0);
        check("rst_out_sign", 32'(out_sign), 32'd0);
        check("rst_out_exp", 32'(out_exp), 32'd0);
        check("rst_out_frac", 32'(out_frac), 32'd0);
        @(posedge clk);
        #1;

        // Scenarios 1-3: single conversions including both zeros.
        single(0, 8'h45);
        single(2, 8'h81);
        single(2, 8'h13);
        single(1, 8'h00);
        single(3, 8'h80);

        // Scenario 4: everyone requesting continuously.
        do_reset();
        obs_ids.delete();
        req_valid = '1;
        req_data  = $urandom();
        for (int i = 0; i < 40; i++) tick();
        req_valid = '0;
        run_until_idle(20);
        tick();
        if (obs_ids.size() >= 6) begin
            check("rr_seq0", 32'(obs_ids[0]), 32'd0);
            check("rr_seq1", 32'(obs_ids[1]), 32'd1);
            check("rr_seq2", 32'(obs_ids[2]), 32'd2);
            check("rr_seq3", 32'(obs_ids[3]), 32'd3);
            check("rr_seq4", 32'(obs_ids[4]), 32'd0);
            check("rr_seq5", 32'(obs_ids[5]), 32'd1);
        end else begin
            check("rr_count", 32'(obs_ids.size()), 32'd6);
        end

        // Scenario 5: backpressure for five cycles once the result appears.
        out_ready    = 1'b0;
        req_valid    = 4'b0010;
        req_data[15:8] = 8'h27;
        tick();
        req_valid = 4'b1111;
        for (int i = 0; i < 20 && !m_valid; i++) tick();
        check("bp_valid_seen", 32'(m_valid), 32'd1);
        repeat (5) tick();
        out_ready = 1'b1;
        req_valid = '0;
        tick();
        tick();

        // Scenario 6: reset while normalising; nothing may come out.
        req_valid = 4'b0010;
        req_data[15:8] = 8'h01;
        tick();
        req_valid = '0;
        tick();
        tick();
        do_reset();
        for (int i = 0; i < 12; i++) tick();
        req_valid = 4'b1010;
        req_data  = 32'h0505_0505;
        tick();
        req_valid = '0;
        run_until_idle(20);
        tick();

        // Random traffic with occasional backpressure and resets.
        for (int i = 0; i < 4000; i++) begin
            req_valid = N'($urandom());
            req_data  = $urandom();
            out_ready = ($urandom_range(0, 9) < 7);
            reset     = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset     = 1'b0;
        out_ready = 1'b1;
        req_valid = '0;
        run_until_idle(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/int_to_fp_sched.md
Name: int_to_fp_sched

Overview:
Shared, multi-cycle signed-integer-to-floating-point conversion engine serving N requesters.
- Round-robin arbiter grants one requester at a time.
- An FSM normalizes the 7-bit magnitude by shifting one bit per clock, producing sign/exp/frac in the codebase's 8-bit sign-magnitude to (1-bit sign, 4-bit exp, 8-bit frac) format.
- Sits between multiple integer producers and a single downstream FP consumer, using valid/ready handshakes on both sides.

Parameters:
ID_W, 2, width of requester index; N = 2**ID_W requesters (ID_W range 1..3)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  N  per-requester request valid
req_data  input  8*N  requester i uses bits [8i+7:8i]; bit 7 = sign, bits 6:0 = magnitude
req_ready  output  N  one-hot grant/accept, combinational, asserted only in IDLE
out_valid  output  1  result valid (registered)
out_ready  input  1  downstream accepts result
out_id  output  ID_W  index of requester that produced the result
out_sign  output  1  sign of result
out_exp  output  4  exponent: leading-one position + 1; 0 for zero magnitude
out_frac  output  8  normalized fraction, leading one at bit 7; 0 for zero magnitude
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - state=IDLE, rr pointer=0, out_valid=0, out_id=0, out_sign=0, out_exp=0, out_frac=0, internal shift reg/counter=0.
  - req_ready forced to 0 while reset is high.
- States: IDLE, NORM, DONE.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching ptr, ptr+1, ..., wrapping mod N.
  - req_ready[winner]=1; all other bits 0. If no req_valid, req_ready=0 and state stays IDLE.
  - Accept edge (valid & ready) captures:
    - sign = data[7]
    - sreg = {data[6:0],1'b0}
    - ecnt = 7
    - id = winner
  - Next state is NORM.
- NORM, evaluated each cycle:
  - sreg==0: load out_exp=0, out_frac=0 and go to DONE.
  - sreg[7]==1: load out_exp=ecnt, out_frac=sreg and go to DONE.
  - Otherwise: sreg <= sreg<<1, ecnt <= ecnt-1, stay in NORM.
  - out_sign and out_id are loaded on entry to DONE.
- Latency (edges from accept edge to the edge that raises out_valid):
  - 7-p, where p = index of the highest set magnitude bit (6..0).
  - 1 for zero magnitude. Range 1..7.
- DONE:
  - out_valid=1; all out_* held stable while out_ready=0.
  - On edge with out_ready=1: out_valid<=0, ptr<=(id+1) mod N, state<=IDLE.
  - req_ready=0 throughout NORM and DONE. Next accept is earliest one cycle after return to IDLE.
- Sign handling: sign is passed through regardless of magnitude. 0x80 yields sign=1, exp=0, frac=0 (negative zero preserved).
- Requester data is sampled only on the accept edge and may change afterwards.
- A deasserted req_valid is never granted. Requesters may drop valid while not granted.
- Reset mid-operation (NORM or DONE): in-flight result discarded, no out_valid pulse; state returns to IDLE with ptr=0.
- Simultaneous requests: exactly one grant per IDLE cycle.
- Round-robin fairness: with all N requesters continuously valid, each is served once per N results.

Test Plan:
1. Single request, id 0, req_data=0x45 (+69). Required: req_ready=0001 in the accept cycle; out_valid 1 edge later; out_sign=0, out_exp=7, out_frac=0x8A, out_id=0.
2. Single request, id 2, req_data=0x81 (-1). Required: out_valid 7 edges after accept; out_sign=1, out_exp=1, out_frac=0x80, out_id=2. Also req_data=0x13: out_exp=5, out_frac=0x98, latency 3.
3. Zero inputs: req_data=0x00 -> sign 0, exp 0, frac 0; req_data=0x80 -> sign 1, exp 0, frac 0. Both with latency 1, out_ready=1.
4. All four req_valid held high with out_ready=1. Required: out_id sequence 0,1,2,3,0,1; busy high except single IDLE cycles between jobs.
5. Backpressure: out_ready=0 for 5 cycles after out_valid rises. Required: out_* unchanged, req_ready=0000, busy=1; completes on the first edge with out_ready=1.
6. Assert reset for 1 cycle during NORM (input 0x01). Required: next cycle out_valid=0, busy=0, state IDLE, ptr=0; no result ever emitted for that request.
